// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode and ALU-op constants, control-word type and main decoder for id_ex_ctrl.
// BNE_EN adds the BNE opcode to the decoder.
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [2:0] ALU_LW   = 3'b000;
  localparam logic [2:0] ALU_BEQ  = 3'b001;
  localparam logic [2:0] ALU_R    = 3'b010;
  localparam logic [2:0] ALU_ADDI = 3'b011;
  localparam logic [2:0] ALU_SLTI = 3'b100;
  localparam logic [2:0] ALU_SW   = 3'b101;
  localparam logic [2:0] ALU_BNE  = 3'b110;
  localparam logic [2:0] ALU_ILL  = 3'b111;
  typedef struct packed {
    logic regWrite;
    logic aluSrc;
    logic branch;
`ifdef BNE_EN
    logic branchNe;
`endif
    logic memWrite;
    logic memRead;
    logic memtoReg;
    logic illegal;
    logic regDst;
    logic usesRt;
    logic [2:0] aluOp;
  } ctrl_t;
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R:    begin c.regWrite = 1'b1; c.regDst = 1'b1; c.usesRt = 1'b1; c.aluOp = ALU_R; end
      OP_LW:   begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.memRead = 1'b1; c.memtoReg = 1'b1; c.aluOp = ALU_LW; end
      OP_SW:   begin c.aluSrc = 1'b1; c.memWrite = 1'b1; c.usesRt = 1'b1; c.aluOp = ALU_SW; end
      OP_ADDI: begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALU_ADDI; end
      OP_SLTI: begin c.regWrite = 1'b1; c.aluSrc = 1'b1; c.aluOp = ALU_SLTI; end
      OP_BEQ:  begin c.branch = 1'b1; c.usesRt = 1'b1; c.aluOp = ALU_BEQ; end
`ifdef BNE_EN
      OP_BNE:  begin c.branch = 1'b1; c.branchNe = 1'b1; c.usesRt = 1'b1; c.aluOp = ALU_BNE; end
`endif
      default: begin c.illegal = 1'b1; c.aluOp = ALU_ILL; end
    endcase
    return c;
  endfunction
endpackage

// File: rtl/id_ex_ctrl_load_use_detect.sv
// load_use_detect: flags an ID source register that matches a load still sitting in EX.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  idValid,
  input  logic                  usesRt,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exWrAddr,
  output logic                  hazard
);
  // $0 is hardwired, so a load targeting it never creates a dependency
  assign hazard = idValid && exValid && exMemRead && (exWrAddr != '0) &&
                  ((exWrAddr == rs) || (usesRt && (exWrAddr == rt)));
endmodule

// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: main decode plus ID/EX control register with load-use bubbles, flush, hold and stall counter.
// Defining BNE_EN decodes BNE and adds the ex_BranchNe_o port.
module id_ex_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [5:0]            instr_op_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  input  logic                  ex_hold_i,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic                  ex_RegWrite_o,
  output logic                  ex_ALUSrc_o,
  output logic                  ex_Branch_o,
  output logic                  ex_MemWrite_o,
  output logic                  ex_MemRead_o,
  output logic                  ex_MemtoReg_o,
  output logic                  ex_illegal_o,
`ifdef BNE_EN
  output logic                  ex_BranchNe_o,
`endif
  output logic [ALU_OP_W-1:0]   ex_ALU_op_o,
  output logic [REG_ADDR_W-1:0] ex_wr_addr_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);
  ctrl_t dec;
  logic hazard;
  logic load;
  assign dec = decode(instr_op_i);
  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .idValid  (valid_i),
    .usesRt   (dec.usesRt),
    .rs       (rs_i),
    .rt       (rt_i),
    .exValid  (ex_valid_o),
    .exMemRead(ex_MemRead_o),
    .exWrAddr (ex_wr_addr_o),
    .hazard   (hazard)
  );
  assign stall_o = ex_hold_i || (hazard && !flush_i);
  // flush, hazard and an empty ID slot all load the same all-zero bubble
  assign load = valid_i && !flush_i && !hazard;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_RegWrite_o <= 1'b0;
      ex_ALUSrc_o   <= 1'b0;
      ex_Branch_o   <= 1'b0;
      ex_MemWrite_o <= 1'b0;
      ex_MemRead_o  <= 1'b0;
      ex_MemtoReg_o <= 1'b0;
      ex_illegal_o  <= 1'b0;
`ifdef BNE_EN
      ex_BranchNe_o <= 1'b0;
`endif
      ex_ALU_op_o   <= '0;
      ex_wr_addr_o  <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (!ex_hold_i) begin
        ex_valid_o    <= load;
        ex_RegWrite_o <= load && dec.regWrite;
        ex_ALUSrc_o   <= load && dec.aluSrc;
        ex_Branch_o   <= load && dec.branch;
        ex_MemWrite_o <= load && dec.memWrite;
        ex_MemRead_o  <= load && dec.memRead;
        ex_MemtoReg_o <= load && dec.memtoReg;
        ex_illegal_o  <= load && dec.illegal;
`ifdef BNE_EN
        ex_BranchNe_o <= load && dec.branchNe;
`endif
        ex_ALU_op_o   <= load ? ALU_OP_W'(dec.aluOp) : '0;
        ex_wr_addr_o  <= load ? (dec.regDst ? rd_i : rt_i) : '0;
      end
      if (stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
endmodule
